// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers op/a/b, stage 2 computes and registers result+flags.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate signed on overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;

  logic s2_take, accept;

  // Stage 2 can load whenever it is empty or its current result leaves this cycle.
  assign s2_take  = !out_valid || out_ready;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  logic [WIDTH:0]    sum, diff;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  raw, fin;
  logic              c_carry, c_ovf;

  always_comb begin
    sum     = {1'b0, s1_a} + {1'b0, s1_b};
    diff    = {1'b0, s1_a} - {1'b0, s1_b};
    shamt   = s1_b[SH_W-1:0];
    raw     = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        raw     = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        raw     = diff[WIDTH-1:0];
        c_carry = diff[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  raw = s1_a & s1_b;
      OP_OR:   raw = s1_a | s1_b;
      OP_XOR:  raw = s1_a ^ s1_b;
      OP_SHL:  raw = s1_a << shamt;
      OP_SHR:  raw = s1_a >> shamt;
      OP_PASS: raw = s1_b;
      default: raw = '0;
    endcase
    fin = raw;
`ifdef ALU_SAT_EN
    // On overflow the sign of a gives the direction for both ADD and SUB.
    if (c_ovf)
      fin = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    fin = raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      op_count  <= '0;
    end else begin
      if (out_valid && out_ready && (op_count != {CNT_W{1'b1}}))
        op_count <= op_count + 1'b1;

      if (s2_take) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result   <= fin;
          carry    <= c_carry;
          zero     <= (fin == '0);
          overflow <= c_ovf;
        end
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= op;
        s1_a     <= a;
        s1_b     <= b;
      end else if (s2_take) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
